// File: rtl/adxl_spi_pkg.sv
// adxl_spi_pkg: shared definitions for the ADXL345 SPI link.
//   - FSM state enum for spi_master_phy
//   - command packet field positions
//   - frame / RX byte lengths and the default SCLK half-period
package adxl_spi_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StShift,
        StHold,
        StDone,
        StRelease
    } spi_state_e;

    // Command packet layout
    localparam int unsigned RW_BIT  = 15;
    localparam int unsigned MB_BIT  = 14;
    localparam int unsigned ADDR_HI = 13;
    localparam int unsigned ADDR_LO = 8;
    localparam int unsigned DATA_HI = 7;
    localparam int unsigned DATA_LO = 0;

    localparam int unsigned FRAME_LEN = 16;
    localparam int unsigned RX_LEN    = 8;

    // 25 clk cycles per SCLK half-period: 1 MHz SCLK from 50 MHz
    localparam int unsigned CLK_DIV_DEFAULT = 25;

endpackage

// File: rtl/spi_tick_gen.sv
// spi_tick_gen: half-period down-counter for the SPI engine.
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset
//   clr_i    reload counter to H-1 (suppresses tick)
//   tick_o   1-cycle pulse every H cycles after clr_i is released
module spi_tick_gen #(
    parameter int unsigned H = 25
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic clr_i,
    output logic tick_o
);

    localparam logic [7:0] RELOAD = 8'(H - 1);

    logic [7:0] r_cnt;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_cnt <= RELOAD;
        end else if (clr_i || (r_cnt == 8'd0)) begin
            r_cnt <= RELOAD;
        end else begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    assign tick_o = (r_cnt == 8'd0) && !clr_i;

endmodule

// File: rtl/spi_master_phy.sv
// spi_master_phy: SPI mode-3 master for the ADXL345 link.
// Shifts a 16-bit command out MSB first and captures the last 8 MISO bits.
//   clk_i     system clock
//   rst_n_i   asynchronous active-low reset
//   req_i     transfer request (level), latched in IDLE
//   pachet_i  16-bit command packet
//   ack_o     1-cycle pulse, frame done, pachet_o valid
//   pachet_o  byte captured on MISO during bits 7..0
//   cs_n_o    chip select, active low
//   sclk_o    SPI clock, idles high
//   mosi_o    SPI data out
//   miso_i    SPI data in (already synchronised)
module spi_master_phy
    import adxl_spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = CLK_DIV_DEFAULT
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        req_i,
    input  logic [15:0] pachet_i,
    output logic        ack_o,
    output logic [7:0]  pachet_o,
    output logic        cs_n_o,
    output logic        sclk_o,
    output logic        mosi_o,
    input  logic        miso_i
);

    localparam logic [3:0] LAST_BIT     = 4'(FRAME_LEN - 1);
    localparam logic [3:0] FIRST_RX_BIT = 4'(FRAME_LEN - RX_LEN);

    spi_state_e            r_state;
    logic [FRAME_LEN-1:0]  r_tx;
    logic [RX_LEN-1:0]     r_rx;
    logic [RX_LEN-1:0]     r_pachet;
    logic [3:0]            r_bit;
    logic                  r_cs_n;
    logic                  r_sclk;
    logic                  r_mosi;
    logic                  r_ack;
    logic                  r_req_low;
    logic                  r_waited;

    logic                  w_tick;
    logic                  w_clr;

    // Divider is held in reload while idle so the first tick lands H cycles after E0.
    // It then free-runs for the rest of the frame, giving ticks at E0 + n*H.
    assign w_clr = (r_state == StIdle);

    spi_tick_gen #(
        .H (CLK_DIV)
    ) u_tick (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .clr_i   (w_clr),
        .tick_o  (w_tick)
    );

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            r_state   <= StIdle;
            r_tx      <= '0;
            r_rx      <= '0;
            r_pachet  <= '0;
            r_bit     <= '0;
            r_cs_n    <= 1'b1;
            r_sclk    <= 1'b1;
            r_mosi    <= 1'b0;
            r_ack     <= 1'b0;
            r_req_low <= 1'b0;
            r_waited  <= 1'b0;
        end else begin
            r_ack <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (req_i) begin
                        r_tx      <= pachet_i;
                        r_cs_n    <= 1'b0;
                        r_bit     <= '0;
                        r_req_low <= 1'b0;
                        r_waited  <= 1'b0;
                        r_state   <= StSetup;
                    end
                end
                StSetup: begin
                    if (w_tick) begin
                        // Falling edge of bit 0
                        r_sclk  <= 1'b0;
                        r_mosi  <= r_tx[FRAME_LEN-1];
                        r_tx    <= {r_tx[FRAME_LEN-2:0], 1'b0};
                        r_state <= StShift;
                    end
                end
                StShift: begin
                    if (w_tick) begin
                        if (!r_sclk) begin
                            // Rising edge: sample MISO, keep only the data-phase bits
                            r_sclk <= 1'b1;
                            if (r_bit >= FIRST_RX_BIT) begin
                                r_rx <= {r_rx[RX_LEN-2:0], miso_i};
                            end
                            if (r_bit == LAST_BIT) begin
                                r_state <= StHold;
                            end
                        end else begin
                            r_sclk <= 1'b0;
                            r_mosi <= r_tx[FRAME_LEN-1];
                            r_tx   <= {r_tx[FRAME_LEN-2:0], 1'b0};
                            r_bit  <= r_bit + 4'd1;
                        end
                    end
                end
                StHold: begin
                    if (w_tick) begin
                        r_cs_n   <= 1'b1;
                        r_mosi   <= 1'b0;
                        r_pachet <= r_rx;
                        r_ack    <= 1'b1;
                        r_state  <= StDone;
                    end
                end
                StDone: begin
                    if (!req_i) begin
                        r_req_low <= 1'b1;
                    end
                    r_state <= StRelease;
                end
                StRelease: begin
                    if (!req_i) begin
                        r_req_low <= 1'b1;
                    end
                    if (w_tick) begin
                        r_waited <= 1'b1;
                    end
                    // Leave only after the CS-high gap and once the request was dropped
                    if ((w_tick || r_waited) && (r_req_low || !req_i)) begin
                        r_state <= StIdle;
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign ack_o    = r_ack;
    assign pachet_o = r_pachet;
    assign cs_n_o   = r_cs_n;
    assign sclk_o   = r_sclk;
    assign mosi_o   = r_mosi;

endmodule

// File: tb/tb_spi_master_phy.sv
// tb_spi_master_phy: self-checking bench for spi_master_phy.
// Two instances (H=2 and H=25) share stimulus; a selector routes the request
// and monitored outputs to the instance under test. A cycle-level slave model
// records MOSI, drives MISO, and measures frame timing against the protocol rules.
module tb_spi_master_phy;
    import adxl_spi_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        t_req;
    logic [15:0] pachet;
    logic        miso;
    bit          sel;

    logic        req2, ack2, cs2, sclk2, mosi2;
    logic [7:0]  pk2;
    logic        req25, ack25, cs25, sclk25, mosi25;
    logic [7:0]  pk25;

    logic        m_ack, m_cs, m_sclk, m_mosi;
    logic [7:0]  m_pachet;

    int n_cmp = 0;
    int n_bad = 0;
    int cyc = 0;
    int last_rise_cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign req2  = t_req && !sel;
    assign req25 = t_req && sel;

    always_comb begin
        m_ack    = sel ? ack25  : ack2;
        m_cs     = sel ? cs25   : cs2;
        m_sclk   = sel ? sclk25 : sclk2;
        m_mosi   = sel ? mosi25 : mosi2;
        m_pachet = sel ? pk25   : pk2;
    end

    spi_master_phy #(.CLK_DIV(2)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .req_i    (req2),
        .pachet_i (pachet),
        .ack_o    (ack2),
        .pachet_o (pk2),
        .cs_n_o   (cs2),
        .sclk_o   (sclk2),
        .mosi_o   (mosi2),
        .miso_i   (miso)
    );

    spi_master_phy #(.CLK_DIV(25)) dut25 (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .req_i    (req25),
        .pachet_i (pachet),
        .ack_o    (ack25),
        .pachet_o (pk25),
        .cs_n_o   (cs25),
        .sclk_o   (sclk25),
        .mosi_o   (mosi25),
        .miso_i   (miso)
    );

    typedef struct packed {
        logic [15:0] tx;
        logic [7:0]  rx;
        logic        cs_at_ack;
        logic        timeout;
        int          rises;
        int          falls;
        int          tim_err;
        int          cs_low;
        int          ack_dly;
        int          ack_w;
        int          gap;
    } frame_t;

    typedef struct {
        logic [15:0] pkt;
        logic [7:0]  resp;
        logic        rw;
        logic [5:0]  addr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    // Slave model + protocol monitor for one frame, sampled on negedge clk.
    task automatic run_frame(input logic [15:0] pkt, input logic [7:0] resp,
                             input bit drop_mid, input bit hold_req, output frame_t f);
        int h, n, e0, ack_n, k, limit;
        bit started, done;
        logic p_cs, p_sclk;
        h = sel ? 25 : 2;
        f = '0;
        started = 0;
        done = 0;
        e0 = 0;
        ack_n = -1;
        @(negedge clk);
        pachet = pkt;
        t_req = 1'b1;
        p_cs = m_cs;
        p_sclk = m_sclk;
        limit = 40 * h + 100;
        n = 0;
        while (!done && n < limit) begin
            @(negedge clk);
            n++;
            if (!started && p_cs && !m_cs) begin
                started = 1;
                e0 = n;
                f.gap = cyc - last_rise_cyc;
            end
            if (started && !m_cs) f.cs_low++;
            if (started && p_sclk && !m_sclk) begin
                k = f.falls;
                if (n - e0 != (2 * k + 1) * h) f.tim_err++;
                f.tx = {f.tx[14:0], m_mosi};
                f.falls++;
                // Address phase: MISO is junk that must be discarded
                miso = (k >= 8) ? resp[15 - k] : 1'($urandom_range(1));
                if (drop_mid && k == 5) begin
                    pachet = 16'hFFFF;
                    t_req = 1'b0;
                end
            end
            if (started && !p_sclk && m_sclk) begin
                k = f.rises;
                if (n - e0 != (2 * k + 2) * h) f.tim_err++;
                f.rises++;
            end
            if (!started && !m_sclk) f.tim_err++;
            if (ack_n >= 0) done = 1;
            if (m_ack) begin
                f.ack_w++;
                if (ack_n < 0) begin
                    ack_n = n;
                    f.ack_dly = n - e0;
                    f.rx = m_pachet;
                    f.cs_at_ack = m_cs;
                    last_rise_cyc = cyc;
                    if (!hold_req) t_req = 1'b0;
                end
            end
            p_cs = m_cs;
            p_sclk = m_sclk;
        end
        f.timeout = !done;
    endtask

    task automatic check_frame(input string tag, input frame_t f, input logic [15:0] pkt,
                               input logic [7:0] resp, input int h);
        chk({tag, " timeout"}, 32'(f.timeout), 32'd0);
        chk({tag, " mosi bits"}, 32'(f.tx), 32'(pkt));
        chk({tag, " rising edges"}, f.rises, 16);
        chk({tag, " falling edges"}, f.falls, 16);
        chk({tag, " edge timing errors"}, f.tim_err, 0);
        chk({tag, " cs low cycles"}, f.cs_low, 33 * h);
        chk({tag, " ack delay"}, f.ack_dly, 33 * h);
        chk({tag, " ack width"}, f.ack_w, 1);
        chk({tag, " cs high at ack"}, 32'(f.cs_at_ack), 32'd1);
        chk({tag, " rx byte"}, 32'(f.rx), 32'(resp));
    endtask

    initial begin
        vec_t   tbl[6];
        frame_t f;
        int     cnt, n, nf;
        logic   p;
        logic [15:0] rpkt;
        logic [7:0]  rresp;
        bit     dm;

        tbl[0] = '{16'h310C, 8'h3C, 1'b0, 6'h31};
        tbl[1] = '{16'h2C0B, 8'h00, 1'b0, 6'h2C};
        tbl[2] = '{16'h2D08, 8'h5A, 1'b0, 6'h2D};
        tbl[3] = '{16'hB300, 8'hA5, 1'b1, 6'h33};
        tbl[4] = '{16'h8000, 8'hFF, 1'b1, 6'h00};
        tbl[5] = '{16'h7FFF, 8'h81, 1'b0, 6'h3F};

        rst_n = 1'b0;
        t_req = 1'b0;
        pachet = 16'h0000;
        miso = 1'b0;
        sel = 0;

        // Reset and idle
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset cs_n", 32'(m_cs), 32'd1);
        chk("reset sclk", 32'(m_sclk), 32'd1);
        chk("reset mosi", 32'(m_mosi), 32'd0);
        chk("reset ack", 32'(m_ack), 32'd0);
        chk("reset pachet_o", 32'(m_pachet), 32'd0);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (!m_sclk || !m_cs || m_ack) cnt++;
        end
        chk("idle activity", cnt, 0);

        // Back-to-back sequencer traffic, req dropped on ack
        for (int i = 0; i < 6; i++) begin
            run_frame(tbl[i].pkt, tbl[i].resp, 0, 0, f);
            check_frame($sformatf("vec%0d", i), f, tbl[i].pkt, tbl[i].resp, 2);
            chk($sformatf("vec%0d rw", i), 32'(f.tx[RW_BIT]), 32'(tbl[i].rw));
            chk($sformatf("vec%0d addr", i), 32'(f.tx[ADDR_HI:ADDR_LO]), 32'(tbl[i].addr));
            chk($sformatf("vec%0d cs gap ok", i), 32'(f.gap >= 2), 32'd1);
        end

        // Request held high through ack: no second frame
        run_frame(16'h2D08, 8'h11, 0, 1, f);
        check_frame("held-req", f, 16'h2D08, 8'h11, 2);
        cnt = 0;
        repeat (100) begin
            @(negedge clk);
            if (!m_cs || m_ack) cnt++;
        end
        chk("held-req restart", cnt, 0);
        t_req = 1'b0;
        repeat (3) @(negedge clk);

        // Input stability: packet changed and req dropped mid-frame
        run_frame(16'h310C, 8'h6E, 1, 0, f);
        check_frame("stability", f, 16'h310C, 8'h6E, 2);

        // Abort during bit 5
        @(negedge clk);
        pachet = 16'h310C;
        t_req = 1'b1;
        p = m_sclk;
        nf = 0;
        n = 0;
        while (nf < 6 && n < 200) begin
            @(negedge clk);
            n++;
            if (p && !m_sclk) nf++;
            p = m_sclk;
        end
        chk("abort reached bit 5", nf, 6);
        rst_n = 1'b0;
        #1;
        chk("abort cs_n", 32'(m_cs), 32'd1);
        chk("abort sclk", 32'(m_sclk), 32'd1);
        chk("abort mosi", 32'(m_mosi), 32'd0);
        chk("abort pachet_o", 32'(m_pachet), 32'd0);
        t_req = 1'b0;
        cnt = 0;
        repeat (4) begin
            @(negedge clk);
            if (m_ack || !m_cs) cnt++;
        end
        rst_n = 1'b1;
        repeat (4) begin
            @(negedge clk);
            if (m_ack || !m_cs) cnt++;
        end
        chk("abort no ack", cnt, 0);
        run_frame(16'h310C, 8'hC3, 0, 0, f);
        check_frame("after-abort", f, 16'h310C, 8'hC3, 2);

        // Randomized frames against the slave model
        for (int i = 0; i < 12; i++) begin
            rpkt = 16'($urandom);
            rresp = 8'($urandom);
            dm = 1'($urandom_range(1));
            run_frame(rpkt, rresp, dm, 0, f);
            check_frame($sformatf("rand%0d", i), f, rpkt, rresp, 2);
        end

        // Write frame at CLK_DIV=25
        repeat (4) @(negedge clk);
        sel = 1;
        run_frame(16'h310C, 8'h96, 0, 0, f);
        check_frame("div25", f, 16'h310C, 8'h96, 25);
        chk("div25 ack at 825", f.ack_dly, 825);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
